// File: rtl/gb_lcd_pkg.sv
// Shared types and constants for the Game Boy LCD pixel-bus transmitter.
package gb_lcd_pkg;

    localparam int GB_WIDTH  = 160;
    localparam int GB_HEIGHT = 144;

    typedef enum logic [1:0] {
        SHADE_WHITE = 2'b00,
        SHADE_LIGHT = 2'b01,
        SHADE_DARK  = 2'b10,
        SHADE_BLACK = 2'b11
    } shade_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VSYNC = 3'd1,
        ST_VGAP  = 3'd2,
        ST_SETUP = 3'd3,
        ST_LATCH = 3'd4,
        ST_HOLD  = 3'd5,
        ST_HSYNC = 3'd6,
        ST_HGAP  = 3'd7
    } lcd_state_t;

    // Bits for a down-counter that must hold (largest duration - 1).
    function automatic int phase_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m < 2) begin
            return 1;
        end else begin
            return $clog2(m);
        end
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by the latch, sync and gap phases.
// Loading N-1 makes the current phase last N cycles; done is high on the last one.
module phase_timer #(
    parameter int PH_W = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic [PH_W-1:0] load_value,
    output logic            done
);

    logic [PH_W-1:0] count_r;

    // Count down to zero and park there until the next load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= PH_W'(0);
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != PH_W'(0)) begin
            count_r <= count_r - PH_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == PH_W'(0));

endmodule

// File: rtl/gb_lcd_transmitter.sv
// Game Boy LCD pixel-bus transmitter: turns a 2-bit pixel stream into
// vsync / per-pixel data_latch / hsync framing. Strobes are registered
// decodes of the current state, so they trail the state by one cycle; this
// puts pixel_data one cycle ahead of each latch rise and keeps it stable for
// one cycle after each fall. px_ready tracks the state directly so the
// handshake lines up with SETUP.
module gb_lcd_transmitter
    import gb_lcd_pkg::*;
#(
    parameter int WIDTH        = GB_WIDTH,
    parameter int HEIGHT       = GB_HEIGHT,
    parameter int LATCH_CYCLES = 2,
    parameter int HSYNC_CYCLES = 4,
    parameter int VSYNC_CYCLES = 8,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       px_valid,
    input  logic [1:0] px_data,
    output logic       px_ready,
    output logic [1:0] pixel_data,
    output logic       data_latch,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_done,
    output logic       underflow
);

    localparam int PH_W = phase_width(LATCH_CYCLES, HSYNC_CYCLES, VSYNC_CYCLES, GAP_CYCLES);
    localparam logic [PH_W-1:0] LATCH_LOAD = PH_W'(LATCH_CYCLES - 1);
    localparam logic [PH_W-1:0] HSYNC_LOAD = PH_W'(HSYNC_CYCLES - 1);
    localparam logic [PH_W-1:0] VSYNC_LOAD = PH_W'(VSYNC_CYCLES - 1);
    localparam logic [PH_W-1:0] GAP_LOAD   = PH_W'(GAP_CYCLES - 1);
    localparam logic [7:0]      LAST_COL   = 8'(WIDTH - 1);
    localparam logic [7:0]      LAST_LINE  = 8'(HEIGHT - 1);

    lcd_state_t      state_r;
    lcd_state_t      state_s;
    logic [7:0]      col_r;
    logic [7:0]      line_r;
    logic            load_s;
    logic [PH_W-1:0] load_value_s;
    logic            phase_done_s;
    logic            handshake_s;
    logic            line_last_s;

    assign handshake_s = px_valid & px_ready;
    assign line_last_s = (line_r == LAST_LINE);

    phase_timer #(
        .PH_W(PH_W)
    ) u_phase_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (load_s),
        .load_value (load_value_s),
        .done       (phase_done_s)
    );

    // Next-state logic and phase-timer loads for each timed state.
    always_comb begin
        state_s      = state_r;
        load_s       = 1'b0;
        load_value_s = PH_W'(0);
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s      = ST_VSYNC;
                    load_s       = 1'b1;
                    load_value_s = VSYNC_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_VSYNC: begin
                if (phase_done_s) begin
                    state_s      = ST_VGAP;
                    load_s       = 1'b1;
                    load_value_s = GAP_LOAD;
                end else begin
                    state_s = ST_VSYNC;
                end
            end
            ST_VGAP: begin
                if (phase_done_s) begin
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_VGAP;
                end
            end
            ST_SETUP: begin
                if (handshake_s) begin
                    state_s      = ST_LATCH;
                    load_s       = 1'b1;
                    load_value_s = LATCH_LOAD;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_LATCH: begin
                if (phase_done_s) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_LATCH;
                end
            end
            ST_HOLD: begin
                if (col_r == LAST_COL) begin
                    state_s      = ST_HSYNC;
                    load_s       = 1'b1;
                    load_value_s = HSYNC_LOAD;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_HSYNC: begin
                if (phase_done_s) begin
                    state_s      = ST_HGAP;
                    load_s       = 1'b1;
                    load_value_s = GAP_LOAD;
                end else begin
                    state_s = ST_HSYNC;
                end
            end
            ST_HGAP: begin
                if (!phase_done_s) begin
                    state_s = ST_HGAP;
                end else if (!line_last_s) begin
                    state_s = ST_SETUP;
                end else if (enable) begin
                    state_s      = ST_VSYNC;
                    load_s       = 1'b1;
                    load_value_s = VSYNC_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Column and line position; line stops at the last line rather than wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_r  <= 8'd0;
            line_r <= 8'd0;
        end else begin
            case (state_r)
                ST_VSYNC: begin
                    col_r  <= 8'd0;
                    line_r <= 8'd0;
                end
                ST_HOLD: begin
                    col_r <= col_r + 8'd1;
                end
                ST_HSYNC: begin
                    col_r <= 8'd0;
                end
                ST_HGAP: begin
                    if (phase_done_s && !line_last_s) begin
                        line_r <= line_r + 8'd1;
                    end else begin
                        line_r <= line_r;
                    end
                end
                default: begin
                    col_r  <= col_r;
                    line_r <= line_r;
                end
            endcase
        end
    end

    // Pixel register: loads only on the handshake, cleared when returning to IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pixel_data <= SHADE_WHITE;
        end else if (handshake_s) begin
            pixel_data <= px_data;
        end else if (state_s == ST_IDLE) begin
            pixel_data <= SHADE_WHITE;
        end else begin
            pixel_data <= pixel_data;
        end
    end

    // Sticky underflow: a SETUP cycle without a valid pixel.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            underflow <= 1'b0;
        end else if ((state_r == ST_SETUP) && !px_valid) begin
            underflow <= 1'b1;
        end else begin
            underflow <= underflow;
        end
    end

    // Registered strobes and ready, all decoded from a single state so they never overlap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            px_ready   <= 1'b0;
            vsync      <= 1'b0;
            hsync      <= 1'b0;
            data_latch <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            px_ready   <= (state_s == ST_SETUP);
            vsync      <= (state_r == ST_VSYNC);
            hsync      <= (state_r == ST_HSYNC);
            data_latch <= (state_r == ST_LATCH);
            frame_done <= (state_r == ST_HGAP) && phase_done_s && line_last_s;
        end
    end

endmodule

// File: tb/tb_gb_lcd_transmitter.sv
// Self-checking bench for gb_lcd_transmitter using a reduced frame geometry.
`timescale 1ns/1ps
module tb_gb_lcd_transmitter;

    localparam int W         = 8;
    localparam int H         = 6;
    localparam int LC        = 3;
    localparam int HC        = 3;
    localparam int VC        = 5;
    localparam int GC        = 2;
    localparam int NPIX      = W * H;
    localparam int LINE_CYC  = W * (LC + 2) + HC + GC;
    localparam int FRAME_CYC = VC + GC + H * LINE_CYC;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       px_valid;
    logic [1:0] px_data;
    logic       px_ready;
    logic [1:0] pixel_data;
    logic       data_latch;
    logic       hsync;
    logic       vsync;
    logic       frame_done;
    logic       underflow;

    gb_lcd_transmitter #(
        .WIDTH(W), .HEIGHT(H), .LATCH_CYCLES(LC),
        .HSYNC_CYCLES(HC), .VSYNC_CYCLES(VC), .GAP_CYCLES(GC)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
        .pixel_data(pixel_data), .data_latch(data_latch), .hsync(hsync),
        .vsync(vsync), .frame_done(frame_done), .underflow(underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int   mode;        // 0: col[1:0] pattern, 1: random shades
        int   stall_pix;   // frame pixel index preceded by a stall
        int   stall_len;   // SETUP cycles with px_valid low
        int   exp_cycles;  // vsync rise to frame_done, inclusive
        logic exp_uf;
    } vec_t;

    vec_t vecs[5];

    int n_tests = 0;
    int n_fail  = 0;

    // source model
    logic [1:0] src [NPIX];
    int pix_idx = 0, stall_pix = 0, stall_left = 0;

    // receiver-side monitor state
    int cyc = 0, n_latch = 0, n_hs = 0, n_vrise = 0, n_fd = 0;
    int vrise_cyc = 0, fd_cyc = 0, vs_width = 0;
    int stab_err = 0, ovl_err = 0, tim_err = 0;
    int dl_run = 0, hs_run = 0, vs_run = 0, lat_in_line = 0;
    logic prev_dl = 1'b0, prev_hs = 1'b0, prev_vs = 1'b0, prev_fd = 1'b0;
    logic [1:0] prev_pix = 2'b00;
    logic [1:0] cap [$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({pixel_data, px_ready, data_latch, hsync, vsync, frame_done});
    endfunction

    // Receiver model: captures on the cycle after each latch fall.
    task automatic sample();
        cyc++;
        if (!reset) begin
            prev_dl = 1'b0; prev_hs = 1'b0; prev_vs = 1'b0; prev_fd = 1'b0;
            prev_pix = 2'b00; dl_run = 0; hs_run = 0; vs_run = 0; lat_in_line = 0;
        end else begin
            if (int'(vsync) + int'(hsync) + int'(data_latch) > 1) ovl_err++;
            if (data_latch) begin
                if (pixel_data !== prev_pix) stab_err++;
                dl_run++;
            end else if (prev_dl) begin
                if (pixel_data !== prev_pix) stab_err++;
                if (dl_run != LC) tim_err++;
                cap.push_back(pixel_data);
                n_latch++; lat_in_line++; dl_run = 0;
            end
            if (hsync) begin
                if (!prev_hs) begin
                    n_hs++;
                    if (lat_in_line != W) tim_err++;
                    lat_in_line = 0;
                end
                hs_run++;
            end else if (prev_hs) begin
                if (hs_run != HC) tim_err++;
                hs_run = 0;
            end
            if (vsync) begin
                if (!prev_vs) begin
                    n_vrise++; vrise_cyc = cyc; lat_in_line = 0;
                end
                vs_run++;
            end else if (prev_vs) begin
                vs_width = vs_run; vs_run = 0;
            end
            if (frame_done) begin
                if (prev_fd) tim_err++;
                n_fd++; fd_cyc = cyc;
            end
            prev_dl = data_latch; prev_hs = hsync; prev_vs = vsync;
            prev_fd = frame_done; prev_pix = pixel_data;
        end
    endtask

    // Source: presents src[pix_idx]; withholds it for the stall cycles.
    task automatic drive_edge();
        logic hs;
        if (px_ready && stall_left > 0 && pix_idx == stall_pix) begin
            px_valid = 1'b0;
            stall_left--;
        end else begin
            px_valid = 1'b1;
        end
        px_data = src[pix_idx];
        hs = px_valid & px_ready;
        @(posedge clock);
        if (hs) pix_idx = (pix_idx + 1) % NPIX;
    endtask

    task automatic tick();
        @(negedge clock);
        sample();
        drive_edge();
    endtask

    task automatic fill_src(input int mode);
        for (int i = 0; i < NPIX; i++) begin
            src[i] = (mode == 0) ? 2'(i % W) : 2'($urandom_range(0, 3));
        end
        pix_idx = 0;
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int lat0, hs0, cap0, st0, ov0, te0, vr0, fd0, k, bad;
        fill_src(v.mode);
        stall_pix = v.stall_pix; stall_left = v.stall_len;
        lat0 = n_latch; hs0 = n_hs; cap0 = cap.size(); st0 = stab_err;
        ov0 = ovl_err; te0 = tim_err; vr0 = n_vrise; fd0 = n_fd;
        enable = 1'b1;
        k = 0;
        while (n_vrise == vr0 && k < 20) begin tick(); k++; end
        check({tag, "_vsync_start"}, n_vrise - vr0, 1);
        enable = 1'b0;
        k = 0;
        while (n_fd == fd0 && k < v.exp_cycles + 100) begin tick(); k++; end
        check({tag, "_frame_done_seen"}, n_fd - fd0, 1);
        repeat (12) tick();
        check({tag, "_frame_cycles"}, fd_cyc - vrise_cyc + 1, v.exp_cycles);
        check({tag, "_vsync_width"}, vs_width, VC);
        check({tag, "_latch_count"}, n_latch - lat0, NPIX);
        check({tag, "_hsync_count"}, n_hs - hs0, H);
        bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (cap0 + i >= cap.size()) bad++;
            else if (cap[cap0 + i] !== src[i]) bad++;
        end
        check({tag, "_pixels"}, bad, 0);
        check({tag, "_stability"}, stab_err - st0, 0);
        check({tag, "_overlap"}, ovl_err - ov0, 0);
        check({tag, "_timing"}, tim_err - te0, 0);
        check({tag, "_underflow"}, int'(underflow), int'(v.exp_uf));
        check({tag, "_idle_outputs"}, outs(), 0);
        check({tag, "_no_restart"}, n_vrise - vr0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r3, r4, k, vr0, fd0, fd1, lat0, hs0, cap0, bad, found;
        vec_t vr;

        r3 = int'($urandom_range(1, 6));
        r4 = int'($urandom_range(0, 6));
        vecs[0] = '{0, 0, 0, FRAME_CYC, 1'b0};
        vecs[1] = '{1, 0, 0, FRAME_CYC, 1'b0};
        vecs[2] = '{0, 3 * W + 5, 10, FRAME_CYC + 10, 1'b1};
        vecs[3] = '{1, NPIX - 1, r3, FRAME_CYC + r3, 1'b1};
        vecs[4] = '{1, int'($urandom_range(0, NPIX - 1)), r4, FRAME_CYC + r4, 1'b1};

        reset = 1'b0; enable = 1'b0; px_valid = 1'b0; px_data = 2'b00;
        for (int i = 0; i < NPIX; i++) src[i] = 2'b00;
        repeat (3) begin @(negedge clock); sample(); end
        check("reset_values", outs() + int'(underflow), 0);
        #1 reset = 1'b1;
        repeat (6) tick();
        check("idle_no_enable", outs() + int'(underflow) + n_vrise, 0);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i], $sformatf("v%0d", i));
        end

        // back-to-back frames, then enable dropped during line 3 of the second
        fill_src(0);
        stall_left = 0;
        vr0 = n_vrise; fd0 = n_fd;
        enable = 1'b1;
        k = 0;
        while (n_fd == fd0 && k < 2 * FRAME_CYC) begin tick(); k++; end
        fd1 = fd_cyc;
        k = 0;
        while (n_vrise < vr0 + 2 && k < 10) begin tick(); k++; end
        check("b2b_vsync_gap", vrise_cyc - fd1, 1);
        lat0 = n_latch; hs0 = n_hs; cap0 = cap.size();
        k = 0;
        while (n_hs - hs0 < 3 && k < 2 * FRAME_CYC) begin tick(); k++; end
        enable = 1'b0;
        k = 0;
        while (n_fd < fd0 + 2 && k < 2 * FRAME_CYC) begin tick(); k++; end
        check("drop_frames_done", n_fd - fd0, 2);
        repeat (2 * LINE_CYC) tick();
        check("drop_latch_count", n_latch - lat0, NPIX);
        check("drop_hsync_count", n_hs - hs0, H);
        bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (cap0 + i >= cap.size()) bad++;
            else if (cap[cap0 + i] !== src[i]) bad++;
        end
        check("drop_pixels", bad, 0);
        check("drop_no_restart", n_vrise - vr0, 2);
        check("drop_idle_outputs", outs(), 0);

        // reset while data_latch is high, then a clean frame
        fill_src(1);
        stall_left = 0;
        lat0 = n_latch;
        enable = 1'b1;
        k = 0;
        while (n_latch - lat0 < 2 * W + 3 && k < 2 * FRAME_CYC) begin tick(); k++; end
        found = 0;
        for (int j = 0; j < 40 && found == 0; j++) begin
            @(negedge clock);
            sample();
            if (data_latch) found = 1;
            else drive_edge();
        end
        check("latch_for_reset", found, 1);
        #1 reset = 1'b0;
        #1 check("reset_async", outs() + int'(underflow), 0);
        enable = 1'b0;
        repeat (2) begin @(negedge clock); sample(); end
        check("reset_held_idle", outs() + int'(underflow), 0);
        #1 reset = 1'b1;
        vr = '{1, 0, 0, FRAME_CYC, 1'b0};
        run_frame(vr, "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
